// File: rtl/nt_node_activity_monitor.sv
// nt_node_activity_monitor
// Observes one registered Nt-node output over a programmable window and
// reports toggle count, ones count, a rare-activity flag and (optionally)
// a MISR signature, handed off via a valid/ready result handshake.
// Optional feature macro: NT_MON_MISR_EN (compiles in the 16-bit MISR).
module nt_node_activity_monitor #(
    parameter int WIN_W = 16,
    parameter int CNT_W = 16,
    parameter int SIG_W = 16
) (
    input  logic             I1470,
    input  logic             I1477,
    input  logic             node_in,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic [CNT_W-1:0] thresh,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [CNT_W-1:0] ones_cnt,
    output logic             rare,
    output logic [SIG_W-1:0] signature
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIN_W-1:0] wcnt_q;
    logic [CNT_W-1:0] thr_q;
    logic [CNT_W-1:0] tog_q;
    logic [CNT_W-1:0] ones_q;
    logic [CNT_W-1:0] tog_nx;
    logic [CNT_W-1:0] ones_nx;
    logic             prev_q;
    logic             first_q;
    logic             rare_q;
    logic             start_ok;
    logic             last_smp;
    logic             is_toggle;

    // State register.
    always_ff @(posedge I1470 or negedge I1477) begin
        if (!I1477) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        res_valid = 1'b0;
        start_ok  = 1'b0;
        last_smp  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (win_len != '0)) begin
                    start_ok = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (wcnt_q == WIN_W'(1)) begin
                    last_smp = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating next-count values for the current RUN sample.
    always_comb begin
        is_toggle = !first_q && (node_in != prev_q);
        tog_nx    = tog_q;
        ones_nx   = ones_q;
        if (is_toggle && (tog_q != '1)) begin
            tog_nx = tog_q + CNT_W'(1);
        end
        if (node_in && (ones_q != '1)) begin
            ones_nx = ones_q + CNT_W'(1);
        end
    end

    // Window datapath: capture at start, count during RUN, flag rare on exit.
    always_ff @(posedge I1470 or negedge I1477) begin
        if (!I1477) begin
            wcnt_q  <= '0;
            thr_q   <= '0;
            tog_q   <= '0;
            ones_q  <= '0;
            prev_q  <= 1'b0;
            first_q <= 1'b0;
            rare_q  <= 1'b0;
        end else begin
            if (start_ok) begin
                wcnt_q  <= win_len;
                thr_q   <= thresh;
                tog_q   <= '0;
                ones_q  <= '0;
                first_q <= 1'b1;
                rare_q  <= 1'b0;
            end else if (state_q == RUN) begin
                wcnt_q  <= wcnt_q - WIN_W'(1);
                prev_q  <= node_in;
                first_q <= 1'b0;
                tog_q   <= tog_nx;
                ones_q  <= ones_nx;
                if (last_smp) begin
                    // rare uses the count including the final sample
                    rare_q <= (tog_nx < thr_q);
                end
            end else if ((state_q == DONE) && res_ready) begin
                rare_q <= 1'b0;
            end
        end
    end

    assign toggle_cnt = tog_q;
    assign ones_cnt   = ones_q;
    assign rare       = rare_q;

`ifdef NT_MON_MISR_EN
    logic [SIG_W-1:0] sig_q;

    // MISR: seeded at start, one shift/feedback step per RUN sample.
    always_ff @(posedge I1470 or negedge I1477) begin
        if (!I1477) begin
            sig_q <= '0;
        end else if (start_ok) begin
            sig_q <= '1;
        end else if (state_q == RUN) begin
            sig_q <= {sig_q[SIG_W-2:0], 1'b0}
                   ^ (sig_q[SIG_W-1] ? SIG_W'(16'h1021) : '0)
                   ^ {{(SIG_W-1){1'b0}}, node_in};
        end
    end

    assign signature = sig_q;
`else
    assign signature = '0;
`endif

endmodule

// File: tb/tb_nt_node_activity_monitor.sv
// Directed self-checking bench for nt_node_activity_monitor.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_nt_node_activity_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        node_in = 1'b0;
    logic        start = 1'b0;
    logic [15:0] win_len = '0;
    logic [15:0] thresh = '0;
    logic        res_ready = 1'b0;

    logic        busy, res_valid, rare;
    logic [15:0] toggle_cnt, ones_cnt, signature;
    logic        s_busy, s_res_valid, s_rare;
    logic [1:0]  s_toggle, s_ones;
    logic [15:0] s_sig;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [15:0] hold_tog, hold_ones, hold_sig;
    logic [15:0] exp_sig;

    always #5 clk = ~clk;

    nt_node_activity_monitor #(.WIN_W(16), .CNT_W(16)) dut (
        .I1470(clk), .I1477(rst_n), .node_in(node_in), .start(start),
        .win_len(win_len), .thresh(thresh), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .toggle_cnt(toggle_cnt), .ones_cnt(ones_cnt),
        .rare(rare), .signature(signature)
    );

    nt_node_activity_monitor #(.WIN_W(16), .CNT_W(2)) dut_s (
        .I1470(clk), .I1477(rst_n), .node_in(node_in), .start(start),
        .win_len(win_len), .thresh(thresh[1:0]), .busy(s_busy),
        .res_valid(s_res_valid), .res_ready(res_ready), .toggle_cnt(s_toggle),
        .ones_cnt(s_ones), .rare(s_rare), .signature(s_sig)
    );

`ifdef NT_MON_MISR_EN
    function automatic logic [15:0] misr(input logic [15:0] s, input logic b);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, b};
    endfunction
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_tog", toggle_cnt, 0);
        chk("rst_ones", ones_cnt, 0);
        chk("rst_rare", rare, 0);
        chk("rst_sig", signature, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        // window 1: 8 samples alternating 0,1,...; thresh 0
        win_len = 16'd8; thresh = 16'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("w1_run", {busy, res_valid}, 2'b10);
            node_in = (i % 2) == 1;
            step();
        end
        chk("w1_valid", res_valid, 1);
        chk("w1_tog", toggle_cnt, 7);
        chk("w1_ones", ones_cnt, 4);
        chk("w1_rare", rare, 0);
        chk("w1_sat_tog", s_toggle, 3);
        chk("w1_sat_ones", s_ones, 3);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("w1_idle", {busy, res_valid, rare}, 3'b000);
        chk("w1_keep_tog", toggle_cnt, 7);
        chk("w1_keep_ones", ones_cnt, 4);

        // window 2: 4 samples of constant 1, thresh 2 -> rare
        win_len = 16'd4; thresh = 16'd2; start = 1'b1;
        step();
        start = 1'b0;
        chk("w2_cleared", toggle_cnt, 0);
        node_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("w2_run", res_valid, 0);
            step();
        end
        chk("w2_valid", res_valid, 1);
        chk("w2_tog", toggle_cnt, 0);
        chk("w2_ones", ones_cnt, 4);
        chk("w2_rare", rare, 1);
        chk("w2_sat_rare", s_rare, 1);

        // hold in DONE with res_ready low while pulsing start
        hold_tog = toggle_cnt; hold_ones = ones_cnt; hold_sig = signature;
        for (int i = 0; i < 5; i++) begin
            start = (i % 2) == 0;
            win_len = 16'd3;
            node_in = (i % 2) == 0;
            step();
            chk("hold_state", {busy, res_valid, rare}, 3'b111);
            chk("hold_tog", toggle_cnt, 0);
            chk("hold_ones", ones_cnt, 4);
            chk("hold_sig", signature, hold_sig);
        end
        start = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("hold_exit", {busy, res_valid, rare}, 3'b000);
        chk("hold_keep_ones", ones_cnt, 4);

        // zero-length window requests are ignored
        win_len = 16'd0; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("zero_len", {busy, res_valid}, 2'b00);
        end
        start = 1'b0;

        // minimum window, also the signature check
        win_len = 16'd1; thresh = 16'd0; start = 1'b1;
        step();
        start = 1'b0;
        node_in = 1'b1;
        chk("w1len_run", {busy, res_valid}, 2'b10);
        step();
`ifdef NT_MON_MISR_EN
        exp_sig = misr(16'hFFFF, 1'b1);
`else
        exp_sig = 16'h0000;
`endif
        chk("w1len_valid", res_valid, 1);
        chk("w1len_ones", ones_cnt, 1);
        chk("w1len_tog", toggle_cnt, 0);
        chk("w1len_sig", signature, exp_sig);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // reset during RUN aborts the window
        win_len = 16'd8; thresh = 16'd5; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            node_in = (i % 2) == 0;
            step();
        end
        chk("abort_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_now", {busy, res_valid, rare}, 3'b000);
        chk("abort_tog", toggle_cnt, 0);
        chk("abort_ones", ones_cnt, 0);
        chk("abort_sig", signature, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("abort_after", {busy, res_valid}, 2'b00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
